// File: rtl/sorter_pkg.sv
// Shared defaults and FSM state encoding for the in-place memory bubble sorter.
package sorter_pkg;

  localparam int DATA_W = 8;
  localparam int ADR_W  = 5;
  localparam int DEPTH  = 32;
  localparam int CNT_W  = 10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_CMP  = 3'd3,
    S_WR_A = 3'd4,
    S_WR_B = 3'd5,
    S_NEXT = 3'd6,
    S_DONE = 3'd7
  } state_e;

endpackage

// File: rtl/sorter_datapath.sv
// Operand registers, compare index j, pass counter and the unsigned comparator
// that feed the sorter FSM.
module sorter_datapath
  import sorter_pkg::*;
#(
  parameter int DW  = DATA_W,
  parameter int AW  = ADR_W,
  parameter int DEP = DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          ld_a_i,
  input  logic          ld_b_i,
  input  logic          inc_j_i,
  input  logic          next_pass_i,
  input  logic [DW-1:0] rdata_i,
  output logic [DW-1:0] reg_a_o,
  output logic [DW-1:0] reg_b_o,
  output logic [AW-1:0] j_o,
  output logic          gt_o,
  output logic          pass_end_o,
  output logic          last_pass_o
);

  localparam logic [AW-1:0] ONE      = AW'(1);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEP - 2);

  logic [DW-1:0] reg_a_q;
  logic [DW-1:0] reg_b_q;
  logic [AW-1:0] j_q;
  logic [AW-1:0] pass_q;
  logic [AW-1:0] limit_s;

  // Index and pass counters; a fresh start wins over any advance request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      j_q    <= '0;
      pass_q <= '0;
    end else if (clear_i) begin
      j_q    <= '0;
      pass_q <= '0;
    end else if (next_pass_i) begin
      j_q    <= '0;
      pass_q <= pass_q + ONE;
    end else if (inc_j_i) begin
      j_q    <= j_q + ONE;
    end
  end

  // Operand capture from the asynchronous-read memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_a_q <= '0;
      reg_b_q <= '0;
    end else begin
      if (ld_a_i) reg_a_q <= rdata_i;
      if (ld_b_i) reg_b_q <= rdata_i;
    end
  end

  // Each pass bubbles one more maximum into place, so the scan shrinks by one.
  assign limit_s     = LAST_IDX - pass_q;
  assign gt_o        = (reg_a_q > reg_b_q);
  assign pass_end_o  = (j_q == limit_s);
  assign last_pass_o = (pass_q == LAST_IDX);
  assign reg_a_o     = reg_a_q;
  assign reg_b_o     = reg_b_q;
  assign j_o         = j_q;

endmodule

// File: rtl/mem_bubble_sorter.sv
// Memory-port initiator that bubble-sorts the whole array in place (ascending,
// unsigned) and stops after the first pass without a swap.
module mem_bubble_sorter
  import sorter_pkg::*;
#(
  parameter int DW  = DATA_W,
  parameter int AW  = ADR_W,
  parameter int DEP = DEPTH,
  parameter int CW  = CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] swap_count,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_e        state_q;
  state_e        state_d;
  logic          swapped_q;
  logic [CW-1:0] swap_count_q;
  logic          done_q;

  logic          clear_s;
  logic          ld_a_s;
  logic          ld_b_s;
  logic          inc_j_s;
  logic          next_pass_s;
  logic [DW-1:0] reg_a_s;
  logic [DW-1:0] reg_b_s;
  logic [AW-1:0] j_s;
  logic          gt_s;
  logic          pass_end_s;
  logic          last_pass_s;

  sorter_datapath #(
    .DW  (DW),
    .AW  (AW),
    .DEP (DEP)
  ) u_dp (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (clear_s),
    .ld_a_i      (ld_a_s),
    .ld_b_i      (ld_b_s),
    .inc_j_i     (inc_j_s),
    .next_pass_i (next_pass_s),
    .rdata_i     (mem_rdata),
    .reg_a_o     (reg_a_s),
    .reg_b_o     (reg_b_s),
    .j_o         (j_s),
    .gt_o        (gt_s),
    .pass_end_o  (pass_end_s),
    .last_pass_o (last_pass_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RD_A; else state_d = S_IDLE;
      S_RD_A: state_d = S_RD_B;
      S_RD_B: state_d = S_CMP;
      S_CMP:  if (gt_s) state_d = S_WR_A; else state_d = S_NEXT;
      S_WR_A: state_d = S_WR_B;
      S_WR_B: state_d = S_NEXT;
      S_NEXT: begin
        if (pass_end_s && (!swapped_q || last_pass_s)) state_d = S_DONE;
        else                                           state_d = S_RD_A;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs: memory port, busy and datapath strobes.
  always_comb begin
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_adr     = '0;
    mem_wdata   = '0;
    busy        = (state_q != S_IDLE);
    clear_s     = 1'b0;
    ld_a_s      = 1'b0;
    ld_b_s      = 1'b0;
    inc_j_s     = 1'b0;
    next_pass_s = 1'b0;
    case (state_q)
      S_IDLE: clear_s = start;
      S_RD_A: begin
        mem_rd  = 1'b1;
        mem_adr = j_s;
        ld_a_s  = 1'b1;
      end
      S_RD_B: begin
        mem_rd  = 1'b1;
        mem_adr = j_s + AW'(1);
        ld_b_s  = 1'b1;
      end
      S_WR_A: begin
        mem_wr    = 1'b1;
        mem_adr   = j_s;
        mem_wdata = reg_b_s;
      end
      S_WR_B: begin
        mem_wr    = 1'b1;
        mem_adr   = j_s + AW'(1);
        mem_wdata = reg_a_s;
      end
      S_NEXT: begin
        if (pass_end_s) begin
          next_pass_s = swapped_q && !last_pass_s;
        end else begin
          inc_j_s = 1'b1;
        end
      end
      default: begin
        mem_rd = 1'b0;
      end
    endcase
  end

  // Swap bookkeeping; swapped is per pass, swap_count is per sort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swapped_q    <= 1'b0;
      swap_count_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      swapped_q    <= 1'b0;
      swap_count_q <= '0;
    end else if (state_q == S_WR_B) begin
      swapped_q    <= 1'b1;
      swap_count_q <= swap_count_q + CW'(1);
    end else if (state_q == S_NEXT && pass_end_s) begin
      swapped_q    <= 1'b0;
    end
  end

  // Registered completion pulse: it follows the DONE cycle by one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= (state_q == S_DONE);
  end

  assign done       = done_q;
  assign swap_count = swap_count_q;

endmodule

// File: tb/tb_mem_bubble_sorter.sv
// Directed bench for mem_bubble_sorter with a behavioural async-read memory.
module tb_mem_bubble_sorter;
  import sorter_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, mem_rd, mem_wr;
  logic [9:0] swap_count;
  logic [4:0] mem_adr;
  logic [7:0] mem_wdata, mem_rdata;

  logic [7:0] mem      [32];
  logic [7:0] load_img [32];
  logic [7:0] img      [32];
  logic [7:0] exp_img  [32];
  logic       load_en = 1'b0;
  int         wr_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_bubble_sorter dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .swap_count(swap_count), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_adr];

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 32; i++) mem[i] <= load_img[i];
      wr_count <= 0;
    end else if (mem_wr) begin
      mem[mem_adr] <= mem_wdata;
      wr_count     <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_memory();
    for (int i = 0; i < 32; i++) load_img[i] = img[i];
    @(negedge clk); load_en = 1'b1;
    @(negedge clk); load_en = 1'b0;
  endtask

  // Reference bubble sort with early exit: sorted image, swap count and done latency.
  task automatic model(output int swaps, output int lat);
    logic [7:0] t;
    bit any;
    for (int i = 0; i < 32; i++) exp_img[i] = img[i];
    swaps = 0;
    lat = 1;
    for (int p = 0; p <= 30; p++) begin
      any = 1'b0;
      for (int j = 0; j <= 30 - p; j++) begin
        if (exp_img[j] > exp_img[j+1]) begin
          t = exp_img[j]; exp_img[j] = exp_img[j+1]; exp_img[j+1] = t;
          swaps++; lat += 6; any = 1'b1;
        end else begin
          lat += 4;
        end
      end
      if (!any) break;
    end
  endtask

  // Pulses start, returns edges from the accepting edge until done is seen.
  task automatic run_sort(input bit poke, output int n);
    bit got;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 5000) begin
      if (poke && busy && (n % 37 == 5)) start = 1'b1;
      @(posedge clk); n++;
      #1 start = 1'b0;
      if (done) got = 1'b1;
    end
    if (!got) check("done_timeout", 32'(n), 32'd0);
  endtask

  task automatic check_sorted(input string tag);
    for (int i = 0; i < 32; i++) check({tag, "_mem"}, 32'(mem[i]), 32'(exp_img[i]));
  endtask

  int n, m_sw, m_lat, wr_snap;

  initial begin
    for (int i = 0; i < 32; i++) begin img[i] = 8'd0; load_img[i] = 8'd0; end
    // 1) reset
    #13 rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_swaps", 32'(swap_count), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(S_IDLE));

    // 2) already ascending: one pass, 31 compares x 4 cycles + 1
    for (int i = 0; i < 32; i++) img[i] = 8'(i);
    load_memory();
    run_sort(1'b0, n);
    check("asc_latency", 32'(n), 32'd125);
    check("asc_swaps", 32'(swap_count), 32'd0);
    check("asc_writes", 32'(wr_count), 32'd0);
    check("asc_busy_after", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);

    // 3) descending: every compare swaps, 496 x 6 + 1
    for (int i = 0; i < 32; i++) img[i] = 8'(31 - i);
    for (int i = 0; i < 32; i++) exp_img[i] = 8'(i);
    load_memory();
    run_sort(1'b0, n);
    check("desc_latency", 32'(n), 32'd2977);
    check("desc_swaps", 32'(swap_count), 32'd496);
    check("desc_writes", 32'(wr_count), 32'd992);
    check_sorted("desc");

    // 4) all equal: no swaps, single pass
    for (int i = 0; i < 32; i++) img[i] = 8'hA5;
    for (int i = 0; i < 32; i++) exp_img[i] = 8'hA5;
    load_memory();
    run_sort(1'b0, n);
    check("eq_latency", 32'(n), 32'd125);
    check("eq_swaps", 32'(swap_count), 32'd0);
    check("eq_writes", 32'(wr_count), 32'd0);
    check_sorted("eq");

    // 5) mixed data with duplicates and extremes, start poked while busy
    for (int i = 0; i < 32; i++) img[i] = 8'(((i * 7 + 3) % 11) * 23);
    img[3] = 8'hFF; img[9] = 8'h00; img[20] = 8'hFF; img[28] = 8'h00;
    model(m_sw, m_lat);
    load_memory();
    run_sort(1'b1, n);
    check("mix_latency", 32'(n), 32'(m_lat));
    check("mix_swaps", 32'(swap_count), 32'(m_sw));
    check_sorted("mix");
    for (int i = 0; i < 31; i++) check("mix_nondecr", 32'(mem[i] <= mem[i+1]), 32'd1);
    repeat (3) @(posedge clk);
    #1 check("mix_no_restart", 32'(busy), 32'd0);

    // 6) reset during WR_A of the first swap, then a clean re-sort
    for (int i = 0; i < 32; i++) img[i] = 8'(31 - i);
    load_memory();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (!mem_wr && n < 100) begin @(negedge clk); n++; end
    check("abort_found_wr", 32'(mem_wr), 32'd1);
    check("abort_in_wr_a", 32'(dut.state_q), 32'(S_WR_A));
    rst = 1'b1;
    #1;
    check("abort_outs", {busy, done, mem_rd, mem_wr, mem_adr, mem_wdata, swap_count}, 32'd0);
    wr_snap = wr_count;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_writes", 32'(wr_count), 32'(wr_snap));
    check("abort_idle", 32'(busy), 32'd0);
    for (int i = 0; i < 32; i++) check("abort_intact", 32'(mem[i]), 32'(img[i]));
    for (int i = 0; i < 32; i++) exp_img[i] = 8'(i);
    run_sort(1'b0, n);
    check("resort_swaps", 32'(swap_count), 32'd496);
    check_sorted("resort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
